cell_color_scheduler: RTL and testbench

Owns the 16-cell color-index register bank behind the 4×4 VGA rectangle grid. It sequences every write into the bank and shares write access between two requesters: the keypad path, which advances one cell to its next palette index, and a fill sequencer, which sweeps all 16 cells to one index. It sits between the keypad decoder and the VGA test top. The VGA side reads the bank asynchronously by cell position and uses the returned 3-bit index to address the RGB111 palette memory.

---
 rtl/cell_color_scheduler.sv | 159 +++++++++++++++
 tb/tb_cell_color_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_color_scheduler.sv
// -----------------------------------------------------------------------------
// cell_color_scheduler
//
// Owns the 16-cell palette-index bank behind the 4x4 VGA rectangle grid and
// serialises every write into it. Two requesters share write access:
//   - keypad path : advances one cell to its next palette index (mod 2^DW)
//   - fill path   : sweeps all cells to a single palette index
// Fill has strict priority over keys. A fill requested while the block is
// busy is parked in a one-deep pending slot and served on the next IDLE cycle.
// The VGA side reads the bank combinationally by cell position.
//
// Optional feature macro: VBLANK_SYNC_EN
//   defined   : bank writes (KEY and FILL) only happen in cycles with vblank=1;
//               otherwise the state and the fill counter hold.
//   undefined : vblank is ignored and writes happen every cycle.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   key_valid   keypad requester has a cell code
//   key_code    cell to advance
//   key_ready   block accepts a key this cycle
//   fill_start  one-cycle fill request pulse
//   fill_color  palette index for the fill, sampled with fill_start
//   vblank      vertical blanking flag (used only with VBLANK_SYNC_EN)
//   rd_addr     cell position from the VGA scanner
//   rd_color    palette index of cell rd_addr (combinational)
//   busy        high while the state is KEY or FILL (registered)
//   fill_done   one-cycle pulse after the last fill write
// -----------------------------------------------------------------------------
module cell_color_scheduler #(
  parameter int AW = 4,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [AW-1:0] key_code,
  output logic          key_ready,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_color,
  input  logic          vblank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_color,
  output logic          busy,
  output logic          fill_done
);

  localparam int NCELLS = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [DW-1:0] r_bank [NCELLS];
  logic [AW-1:0] r_code;
  logic [AW-1:0] r_fcnt;
  logic [DW-1:0] r_color;
  logic [DW-1:0] r_pend_color;
  logic          r_fill_pending;
  logic          r_busy;
  logic          r_fill_done;

  logic          w_we;
  logic          w_go_fill;
  logic          w_go_key;
  logic          w_last;

  // Write enable for the bank and for FSM progress out of KEY/FILL.
`ifdef VBLANK_SYNC_EN
  assign w_we = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_we            = 1'b1;
`endif

  // A fill request seen this cycle (new or parked) blocks keys outright.
  assign key_ready = (r_state == ST_IDLE) && !fill_start && !r_fill_pending;
  assign w_go_fill = (r_state == ST_IDLE) && (fill_start || r_fill_pending);
  assign w_go_key  = key_valid && key_ready;
  assign w_last    = (r_state == ST_FILL) && w_we && (r_fcnt == {AW{1'b1}});

  // Next-state logic.
  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go_fill)     w_next = ST_FILL;
        else if (w_go_key) w_next = ST_KEY;
      end
      ST_KEY:  if (w_we)   w_next = ST_IDLE;
      ST_FILL: if (w_last) w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  // Control state: FSM register, fill counter, latched operands, pending slot.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_code         <= '0;
      r_fcnt         <= '0;
      r_color        <= '0;
      r_pend_color   <= '0;
      r_fill_pending <= 1'b0;
      r_busy         <= 1'b0;
      r_fill_done    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != ST_IDLE);
      r_fill_done <= w_last;

      // A fresh fill_start in IDLE wins over the parked color: it is newer.
      if (w_go_fill) begin
        r_color <= fill_start ? fill_color : r_pend_color;
        r_fcnt  <= '0;
      end else if ((r_state == ST_FILL) && w_we) begin
        r_fcnt  <= r_fcnt + AW'(1);  // wraps to 0 after the last cell
      end

      if (w_go_key) r_code <= key_code;

      // Pending slot is one deep; a later pulse simply overwrites the color.
      if (fill_start && (r_state != ST_IDLE)) begin
        r_fill_pending <= 1'b1;
        r_pend_color   <= fill_color;
      end else if (w_go_fill) begin
        r_fill_pending <= 1'b0;
      end
    end
  end

  // Color bank.
  // NOTE: the bank is a register file, not RAM, and is cleared by reset
  // because the display must show index 0 (white) in every cell after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCELLS; i++) r_bank[i] <= '0;
    end else if (w_we) begin
      if (r_state == ST_KEY)       r_bank[r_code] <= r_bank[r_code] + DW'(1);
      else if (r_state == ST_FILL) r_bank[r_fcnt] <= r_color;
    end
  end

  assign rd_color  = r_bank[rd_addr];
  assign busy      = r_busy;
  assign fill_done = r_fill_done;

endmodule

// File: tb/tb_cell_color_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cell_color_scheduler
//
// Self-checking bench for cell_color_scheduler. Keeps a 16-entry array of the
// expected palette indices, updated per completed transaction (key: +1 mod 8,
// fill: all cells set), and compares it against rd_color. Timing of the
// handshake, fill length, pending fills and reset behaviour are checked by
// directed sequences; a table of transactions and a randomized phase follow.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cell_color_scheduler;

  localparam int AW = 4;
  localparam int DW = 3;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_valid = 1'b0;
  logic [AW-1:0] key_code = '0;
  logic          key_ready;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_color = '0;
  logic          vblank = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_color;
  logic          busy;
  logic          fill_done;

  cell_color_scheduler #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .vblank     (vblank),
    .rd_addr    (rd_addr),
    .rd_color   (rd_color),
    .busy       (busy),
    .fill_done  (fill_done)
  );

  // Long period leaves room for 16 sequential 1 ns reads inside one cycle.
  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int model [NC];

  typedef struct {
    int op;    // 0 = key, 1 = fill
    int arg;   // key code or fill color
    int addr;  // cell to read back afterwards
    int exp;   // expected palette index of that cell
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int a, output logic [DW-1:0] v);
    rd_addr = AW'(a);
    #1;
    v = rd_color;
  endtask

  task automatic check_bank(input string name);
    logic [DW-1:0] v;
    for (int c = 0; c < NC; c++) begin
      read_cell(c, v);
      check($sformatf("%s[%0d]", name, c), v, model[c]);
    end
  endtask

  task automatic model_fill(input int color);
    for (int c = 0; c < NC; c++) model[c] = color;
  endtask

  // Present a key, hold it until accepted, then wait for its write edge.
  task automatic do_key(input int code);
    int n = 0;
    key_code  = AW'(code);
    key_valid = 1'b1;
    #1;
    while (!key_ready && n < 200) begin
      step();
      n++;
    end
    check("key_accept_timeout", key_ready, 1);
    step();
    key_valid = 1'b0;
    step();
    model[code] = (model[code] + 1) % 8;
  endtask

  // Called just after the edge that started a fill. Counts busy cycles until
  // the fill_done cycle, where it returns.
  task automatic wait_fill_done(output int busy_cycles, output bit done_seen);
    int n = 0;
    busy_cycles = 0;
    while (!fill_done && n < 200) begin
      if (busy) busy_cycles++;
      step();
      n++;
    end
    done_seen = fill_done;
  endtask

  task automatic do_fill(input int color, input string name);
    int cyc;
    bit done;
    fill_color = DW'(color);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    wait_fill_done(cyc, done);
    check({name, "_done"}, done, 1);
    check({name, "_busy_cycles"}, cyc, 16);
    model_fill(color);
  endtask

  initial begin
    int  cyc;
    bit  done;
    bit  seen_done;
    logic [DW-1:0] v;
    int  color;

    vecs = '{
      '{0,  3,  3, 1}, '{0,  3,  3, 2}, '{1, 7, 15, 7}, '{0, 15, 15, 0},
      '{0,  0,  0, 0}, '{1,  0,  8, 0}, '{0, 8,  8, 1}, '{1,  4,  0, 4},
      '{0, 15, 15, 5}, '{0, 15, 15, 6}, '{0, 15, 15, 7}, '{0, 15, 15, 0},
      '{0,  2,  2, 5}
    };
    for (int c = 0; c < NC; c++) model[c] = 0;

    // ---------------- reset ----------------
    #10 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("rst_key_ready", key_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fill_done", fill_done, 0);
    check_bank("rst_bank");

    // ---------------- key handshake: cell 5 eight times ----------------
    key_code  = 4'd5;
    key_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("hs_ready_hi%0d", i), key_ready, 1);
      step();
      check($sformatf("hs_ready_lo%0d", i), key_ready, 0);
      check($sformatf("hs_busy%0d", i), busy, 1);
      step();
      model[5] = (model[5] + 1) % 8;
      read_cell(5, v);
      check($sformatf("hs_cell5_%0d", i), v, (i + 1) % 8);
    end
    key_valid = 1'b0;
    step();
    check_bank("hs_bank");

    // ---------------- fill with a key in the start cycle ----------------
    key_code   = 4'd9;
    key_valid  = 1'b1;
    fill_color = 3'd3;
    fill_start = 1'b1;
    #1;
    check("fk_key_blocked", key_ready, 0);
    step();
    fill_start = 1'b0;
    wait_fill_done(cyc, done);
    check("fk_done", done, 1);
    check("fk_busy_cycles", cyc, 16);
    model_fill(3);
    check_bank("fk_fill_bank");
    check("fk_key_ready_after", key_ready, 1);
    do_key(9);
    check("fk_fill_done_pulse", fill_done, 0);
    check_bank("fk_bank");

    // ---------------- pending fill ----------------
    fill_color = 3'd6;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (4) step();
    fill_color = 3'd2;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    fill_color = 3'd0;
    wait_fill_done(cyc, done);
    check("pf_first_done", done, 1);
    check("pf_gap_key_ready", key_ready, 0);
    model_fill(6);
    check_bank("pf_first_bank");
    step();
    check("pf_done_one_cycle", fill_done, 0);
    check("pf_second_busy", busy, 1);
    wait_fill_done(cyc, done);
    check("pf_second_done", done, 1);
    check("pf_second_busy_cycles", cyc, 16);
    model_fill(2);
    check_bank("pf_second_bank");

    // ---------------- reset in the middle of a fill ----------------
    fill_color = 3'd5;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (7) step();
    read_cell(6, v);
    check("rm_cell6_written", v, 5);
    read_cell(7, v);
    check("rm_cell7_old", v, 2);
    rst = 1'b0;
    #1;
    model_fill(0);
    check_bank("rm_bank");
    check("rm_busy", busy, 0);
    check("rm_fill_done", fill_done, 0);
    step();
    rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fill_done || busy) seen_done = 1'b1;
      step();
    end
    check("rm_no_resume", seen_done, 0);
    check("rm_key_ready", key_ready, 1);

    // ---------------- transaction table ----------------
    for (int i = 0; i < $size(vecs); i++) begin
      if (vecs[i].op == 0) do_key(vecs[i].arg);
      else                 do_fill(vecs[i].arg, $sformatf("tbl%0d", i));
      read_cell(vecs[i].addr, v);
      check($sformatf("tbl%0d_cell%0d", i, vecs[i].addr), v, vecs[i].exp);
    end
    check_bank("tbl_bank");

    // ---------------- randomized transactions ----------------
    for (int i = 0; i < 30; i++) begin
      int op;
      int arg;
      op  = int'($urandom_range(0, 2));
      arg = int'($urandom_range(0, 15));
      color = int'($urandom_range(0, 7));
      if (op == 0) begin
        do_key(arg);
      end else if (op == 1) begin
        do_fill(color, $sformatf("rnd%0d", i));
      end else begin
        key_code  = AW'(arg);
        key_valid = 1'b1;
        do_fill(color, $sformatf("rnd%0d_kf", i));
        do_key(arg);
      end
      check_bank($sformatf("rnd%0d", i));
    end

`ifdef VBLANK_SYNC_EN
    // ---------------- writes gated by vertical blanking ----------------
    color      = (model[5] + 1) % 8;
    vblank     = 1'b1;
    fill_color = DW'(color);
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (5) step();
    vblank = 1'b0;
    repeat (20) step();
    check("vb_busy_held", busy, 1);
    read_cell(4, v);
    check("vb_cell4_written", v, color);
    read_cell(5, v);
    check("vb_cell5_held", v, model[5]);
    vblank = 1'b1;
    wait_fill_done(cyc, done);
    check("vb_done", done, 1);
    check("vb_remaining_cycles", cyc, 11);
    model_fill(color);
    check_bank("vb_bank");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
